// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative mul/div/divu/rem/remu, one result bit per cycle, 65-cycle latency (1 for b==0 / overflow).
// Result is held in DONE until out_ready; in_ready is low whenever a request is in flight or unaccepted.
module mdu_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state;
  kind_t            kind_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  // opa: multiplicand (mul) or dividend shifting into quotient (div/rem)
  // opb: multiplier (mul) or divisor magnitude (div/rem)
  logic [XLEN-1:0]  opa;
  logic [XLEN-1:0]  opb;
  logic [XLEN-1:0]  acc;
  logic [XLEN:0]    prem;

  // Request decode, only consumed on the acceptance edge
  kind_t           kind_in;
  logic            sgn_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            ovf;

  always_comb begin
    kind_in = K_MUL;
    sgn_in  = 1'b0;
    case (in_op)
      3'd1: begin kind_in = K_DIV; sgn_in = 1'b1; end
      3'd2: kind_in = K_DIV;
      3'd3: begin kind_in = K_REM; sgn_in = 1'b1; end
      3'd4: kind_in = K_REM;
      default: kind_in = K_MUL;
    endcase
    a_neg  = sgn_in & in_a[XLEN-1];
    b_neg  = sgn_in & in_b[XLEN-1];
    a_mag  = a_neg ? -in_a : in_a;
    b_mag  = b_neg ? -in_b : in_b;
    b_zero = (in_b == '0);
    ovf    = sgn_in && (in_a == INT_MIN) && (in_b == '1);
  end

  // One restoring-division step
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] res_raw;

  always_comb begin
    trial = {prem[XLEN-1:0], opa[XLEN-1]};
    diff  = trial - {1'b0, opb};
    ge    = (trial >= {1'b0, opb});
    case (kind_q)
      K_DIV:   res_raw = opa;
      K_REM:   res_raw = prem[XLEN-1:0];
      default: res_raw = acc;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kind_q     <= K_MUL;
      cnt        <= '0;
      neg_q      <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      prem       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            kind_q <= kind_in;
            cnt    <= '0;
            acc    <= '0;
            prem   <= '0;
            if (kind_in == K_MUL) begin
              opa   <= in_a;
              opb   <= in_b;
              neg_q <= 1'b0;
              state <= CALC;
            end else if (b_zero) begin
              // Preloaded answers bypass the iteration entirely
              opa   <= '1;
              prem  <= {1'b0, in_a};
              neg_q <= 1'b0;
              state <= FIX;
            end else if (ovf) begin
              opa   <= in_a;
              prem  <= '0;
              neg_q <= 1'b0;
              state <= FIX;
            end else begin
              opa   <= a_mag;
              opb   <= b_mag;
              neg_q <= (kind_in == K_DIV) ? (a_neg ^ b_neg) : a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kind_q == K_MUL) begin
            acc <= acc + (opa & {XLEN{opb[0]}});
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            prem <= ge ? diff : trial;
            opa  <= {opa[XLEN-2:0], ge};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          out_result <= neg_q ? -res_raw : res_raw;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A restored partial remainder is always below the divisor, so its guard bit stays clear
  a_prem_guard: assert property (@(posedge clk) disable iff (!rst_n) !prem[XLEN]);

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the instruction decoder.
- Consumes instructions the decoder flags with MULDIVREM: mul, div, divu, rem and remu.
- Computes one result bit per cycle, radix-2 (shift-add for mul, restoring division for div/rem).
- Returns a 64-bit result to the writeback mux, slot RD_M = 5/6/7, through a valid/ready handshake.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- in_op  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; codes 5-7 are treated as MUL.
- in_a  in  XLEN  rs1 value.
- in_b  in  XLEN  rs2 value.
- flush  in  1  synchronous abort from pipeline redirect.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- busy  out  1  high in any state other than IDLE (stall source for the decoder/issue stage).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, out_valid=0, out_result=0, busy=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- Acceptance edge (E0): in_valid && in_ready && !flush.
  - Latch the op.
  - Signed ops (DIV/REM): latch operand magnitudes and the result sign.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
  - Other ops: latch operands unsigned.
- Special cases, detected at E0; skip CALC and go straight to FIX with the preloaded answer:
  - b==0: DIV/DIVU give all ones; REM/REMU give a.
  - DIV/REM with a==0x8000_0000_0000_0000 and b==all-ones: DIV gives a, REM gives 0.
  - Resulting latency: out_valid high after E1.
- Normal path:
  - IDLE -> CALC at E0, counter=0.
  - Each CALC edge performs one iteration and increments the counter.
  - After 64 iterations (edge E64, counter wraps from 63) the unit moves to FIX.
  - At E65 FIX applies sign correction (two's-complement negate if the sign flag is set) and registers out_result; state moves to DONE.
  - out_valid high after E65, i.e. fixed latency 65 cycles.
- MUL result: low XLEN bits of the product, identical for signed/unsigned; no sign fixup needed.
- Internal widths:
  - Multiplier accumulator: XLEN bits, wraps.
  - Divider partial remainder: XLEN+1 bits, so the subtract-compare never overflows.
- DONE:
  - out_valid=1 and out_result held stable until out_ready.
  - out_valid && out_ready at an edge: move to IDLE, out_valid=0.
  - No new acceptance in the same cycle (in_ready low in DONE).
- flush:
  - Any state, at an edge: move to IDLE, out_valid=0, counter=0; any in-flight or completed-but-unaccepted result is discarded.
  - flush outranks in_valid and out_ready in the same cycle.
- in_a/in_b/in_op are ignored outside the acceptance edge; operands may change freely while busy.
- Asynchronous reset asserted mid-operation: immediate return to the reset values above. After release the unit accepts a new request on the first edge.

Test Plan:
- MUL 7 x 0xFFFF_FFFF_FFFF_FFFD (-3) -> out_result 0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 65 cycles after acceptance, busy high throughout.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero:
  - DIVU 5/0 -> all ones.
  - REM 0x1234/0 -> 0x1234.
  - Both with out_valid one cycle after acceptance.
- Overflow:
  - DIV 0x8000_0000_0000_0000 / all-ones -> 0x8000_0000_0000_0000.
  - REM on the same operands -> 0.
- Backpressure and flush:
  - Hold out_ready low 5 cycles after out_valid: result stable, in_ready=0.
  - Assert flush 10 cycles into CALC: out_valid never rises, in_ready=1 next cycle, next DIVU 9/3 returns 3.
- Pull rst_n low asynchronously mid-CALC: outputs zero immediately without a clock edge. After release, MUL 6x7 -> 42 at 65 cycles.
